// File: rtl/udp_pktgen.sv
// ---------------------------------------------------------------------------
// udp_pktgen -- GMII Ethernet/IPv4/UDP frame generator (TX side of the PHY).
//
// Frames are: preamble/SFD, 14-byte Ethernet header, 20-byte IPv4 header,
// 8-byte UDP header, patterned payload, zero padding to a 46-byte L2 payload
// and a CRC32 FCS. Frames are sent on START (single shot) or back to back
// while CONT is high, separated by IFG idle cycles plus the checksum prep.
//
// Optional feature (compile-time macro PKTGEN_SEQNUM_EN):
//   defined   -> payload bytes 0..3 carry frm_cnt big-endian, the pattern
//                resumes at byte 4.
//   undefined -> every payload byte carries the pattern.
//
// Ports:
//   tclk     in   1   GMII TX clock, the only clock
//   arstn    in   1   asynchronous active-low reset
//   start    in   1   start one frame, sampled only while idle
//   cont     in   1   continuous mode, next frame follows the gap while high
//   pay_len  in  11   UDP payload length, clamped to MAX_PAY, sampled at start
//   busy     out  1   high from frame start through the end of the gap
//   done     out  1   one-cycle pulse after the last FCS byte
//   frm_cnt  out 32   completed frame count (wraps)
//   txd      out  8   GMII TX data
//   txen     out  1   GMII TX enable
//   txer     out  1   GMII TX error, always 0
// ---------------------------------------------------------------------------
module udp_pktgen #(
  parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC  = 48'h0200_0000_0001,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd5001,
  parameter int          IFG      = 12,
  parameter int          MAX_PAY  = 1472
) (
  input  logic        tclk,
  input  logic        arstn,
  input  logic        start,
  input  logic        cont,
  input  logic [10:0] pay_len,
  output logic        busy,
  output logic        done,
  output logic [31:0] frm_cnt,
  output logic [7:0]  txd,
  output logic        txen,
  output logic        txer
);

  typedef enum logic [2:0] {IDLE, PREP, PRE, HDR, PAY, PAD, FCS, GAP} state_t;

  state_t       state;
  logic [15:0]  cnt;
  logic [10:0]  len;
  logic [19:0]  sum;
  logic [31:0]  crc;
  logic [31:0]  fcs_word;
  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [15:0]  ip_csum;
  logic [15:0]  prep_word;
  logic [335:0] hdr_vec;
  logic [7:0]   nxt_byte;
  logic         last_gap;
  logic         launch;

  function automatic logic [10:0] clamp_len(input logic [10:0] req);
    if (req > 11'(MAX_PAY)) return 11'(MAX_PAY);
    return req;
  endfunction

  // One end-around-carry fold of the 20-bit one's-complement accumulator.
  function automatic logic [19:0] fold_carry(input logic [19:0] s);
    return {4'd0, s[15:0]} + {16'd0, s[19:16]};
  endfunction

  // Reflected CRC32 (0xEDB88320 is 0x04C11DB7 bit-reversed), LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign ip_len   = 16'd28 + {5'd0, len};
  assign udp_len  = 16'd8 + {5'd0, len};
  assign ip_csum  = ~sum[15:0];
  assign fcs_word = ~crc;
  assign txer     = 1'b0;

  // The whole 42-byte header, first transmitted byte in the top bits.
  assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, ip_len, frm_cnt[15:0], 16'h4000, 8'h40, 8'h11,
                    ip_csum, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, 16'h0000};

  assign last_gap = (state == GAP) && (cnt == 16'(IFG - 1));
  assign launch   = ((state == IDLE) && (start || cont)) || (last_gap && cont);

  // IPv4 header words fed to the checksum accumulator, checksum field as 0.
  always_comb begin
    prep_word = 16'h0000;
    case (cnt[3:0])
      4'd0:    prep_word = 16'h4500;
      4'd1:    prep_word = ip_len;
      4'd2:    prep_word = frm_cnt[15:0];
      4'd3:    prep_word = 16'h4000;
      4'd4:    prep_word = 16'h4011;
      4'd6:    prep_word = SRC_IP[31:16];
      4'd7:    prep_word = SRC_IP[15:0];
      4'd8:    prep_word = DST_IP[31:16];
      4'd9:    prep_word = DST_IP[15:0];
      default: prep_word = 16'h0000;
    endcase
  end

  // Byte to be driven on the next edge for the current state/position.
  always_comb begin
    nxt_byte = 8'h00;
    case (state)
      PRE: nxt_byte = (cnt == 16'd7) ? 8'hD5 : 8'h55;
      HDR: nxt_byte = hdr_vec[9'd335 - {cnt[5:0], 3'b000} -: 8];
      PAY: begin
        nxt_byte = frm_cnt[7:0] + cnt[7:0];
`ifdef PKTGEN_SEQNUM_EN
        if (cnt < 16'd4) nxt_byte = frm_cnt[5'd31 - {cnt[1:0], 3'b000} -: 8];
`endif
      end
      FCS:     nxt_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
      default: nxt_byte = 8'h00;
    endcase
  end

  // Control FSM with registered GMII outputs
  always_ff @(posedge tclk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      txd     <= 8'h00;
      txen    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      frm_cnt <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txen <= 1'b0;
          txd  <= 8'h00;
          if (start || cont) begin
            busy  <= 1'b1;
            cnt   <= 16'd0;
            state <= PREP;
          end
        end
        // 10 accumulate cycles + 2 carry folds
        PREP: begin
          if (cnt == 16'd11) begin
            cnt   <= 16'd0;
            state <= PRE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PRE: begin
          txen <= 1'b1;
          txd  <= nxt_byte;
          if (cnt == 16'd7) begin
            cnt   <= 16'd0;
            state <= HDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HDR: begin
          txd <= nxt_byte;
          if (cnt == 16'd41) begin
            cnt   <= 16'd0;
            state <= (len == 11'd0) ? PAD : PAY;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PAY: begin
          txd <= nxt_byte;
          if (cnt == {5'd0, len} - 16'd1) begin
            cnt   <= 16'd0;
            state <= (len < 11'd18) ? PAD : FCS;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // Pad brings the L2 payload up to 46 bytes (18 - len zero bytes)
        PAD: begin
          txd <= nxt_byte;
          if (cnt == 16'd17 - {5'd0, len}) begin
            cnt   <= 16'd0;
            state <= FCS;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FCS: begin
          txd <= nxt_byte;
          if (cnt == 16'd3) begin
            cnt   <= 16'd0;
            state <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          txen <= 1'b0;
          txd  <= 8'h00;
          if (cnt == 16'd0) begin
            done    <= 1'b1;
            frm_cnt <= frm_cnt + 32'd1;
          end
          if (last_gap) begin
            cnt <= 16'd0;
            if (cont) begin
              state <= PREP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: latched length, IP checksum accumulator, running CRC
  always_ff @(posedge tclk) begin
    if (launch) begin
      len <= clamp_len(pay_len);
      sum <= 20'd0;
    end
    case (state)
      PREP: begin
        if (cnt < 16'd10) sum <= sum + {4'd0, prep_word};
        else              sum <= fold_carry(sum);
      end
      PRE:           crc <= 32'hFFFF_FFFF;
      HDR, PAY, PAD: crc <= crc_byte(crc, nxt_byte);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_pktgen.sv
// ---------------------------------------------------------------------------
// tb_udp_pktgen -- directed + randomized bench for udp_pktgen.
// Expected frames are rebuilt byte by byte from the frame format rules; the
// FCS is computed with the non-reflected MSB-first CRC32 on bit-reversed
// bytes and reversed back, the IP checksum with plain integer folding.
// ---------------------------------------------------------------------------
module tb_udp_pktgen;

  localparam logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_MAC  = 48'h0200_0000_0001;
  localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
  localparam logic [31:0] DST_IP   = 32'hC0A8_0002;
  localparam logic [15:0] SRC_PORT = 16'd5000;
  localparam logic [15:0] DST_PORT = 16'd5001;
  localparam int          IFG      = 12;
  localparam int          MAX_PAY  = 1472;

  logic        tclk    = 1'b0;
  logic        arstn   = 1'b0;
  logic        start   = 1'b0;
  logic        cont    = 1'b0;
  logic [10:0] pay_len = 11'd0;
  logic        busy;
  logic        done;
  logic [31:0] frm_cnt;
  logic [7:0]  txd;
  logic        txen;
  logic        txer;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_c, fall_c, done_in;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  udp_pktgen #(
    .DST_MAC(DST_MAC), .SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP), .DST_IP(DST_IP),
    .SRC_PORT(SRC_PORT), .DST_PORT(DST_PORT), .IFG(IFG), .MAX_PAY(MAX_PAY)
  ) dut (
    .tclk(tclk), .arstn(arstn), .start(start), .cont(cont), .pay_len(pay_len),
    .busy(busy), .done(done), .frm_cnt(frm_cnt), .txd(txd), .txen(txen), .txer(txer)
  );

  always #4 tclk = ~tclk;
  always @(posedge tclk) cyc <= cyc + 1;

  initial begin
    repeat (50000) @(posedge tclk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // Reference frame as seen on TXD while TXEN is high.
  task automatic build_expected(input int req, input logic [31:0] fc);
    int L;
    int s;
    logic [15:0] ck;
    logic [31:0] c;
    logic [7:0]  b;
    L = (req > MAX_PAY) ? MAX_PAY : req;
    s = 'h4500 + 28 + L + int'(fc[15:0]) + 'h4000 + 'h4011 +
        int'(SRC_IP[31:16]) + int'(SRC_IP[15:0]) + int'(DST_IP[31:16]) + int'(DST_IP[15:0]);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
    ck = ~s[15:0];
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_be(DST_MAC, 6);
    push_be(SRC_MAC, 6);
    push_be(48'h0800, 2);
    push_be(48'h4500, 2);
    push_be(48'(28 + L), 2);
    push_be({32'd0, fc[15:0]}, 2);
    push_be(48'h4000, 2);
    push_be(48'h4011, 2);
    push_be({32'd0, ck}, 2);
    push_be({16'd0, SRC_IP}, 4);
    push_be({16'd0, DST_IP}, 4);
    push_be({32'd0, SRC_PORT}, 2);
    push_be({32'd0, DST_PORT}, 2);
    push_be(48'(8 + L), 2);
    push_be(48'h0, 2);
    for (int i = 0; i < L; i++) begin
      b = 8'(int'(fc[7:0]) + i);
`ifdef PKTGEN_SEQNUM_EN
      if (i < 4) b = fc[31 - 8*i -: 8];
`endif
      exp_q.push_back(b);
    end
    for (int i = L; i < 18; i++) exp_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int j = 8; j < exp_q.size(); j++) begin
      c = c ^ {rev8(exp_q[j]), 24'd0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    c = ~rev32(c);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic compare_frame(input string tag);
    int mis;
    mis = 0;
    check({tag, " frame length"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mis++;
    check({tag, " mismatching bytes"}, 64'(mis), 64'd0);
  endtask

  // mode 1: drop CONT at byte poke_at; mode 2: pulse START at byte poke_at.
  task automatic get_frame(input int mode, input int poke_at);
    int t;
    t = 0;
    got_q.delete();
    done_in = 0;
    while (txen !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    check("TXEN rise within budget", 64'(txen), 64'd1);
    rise_c = cyc;
    while (txen === 1'b1 && got_q.size() < 2000) begin
      got_q.push_back(txd);
      if (done === 1'b1) done_in++;
      if (got_q.size() == poke_at) begin
        if (mode == 1) cont = 1'b0;
        if (mode == 2) start = 1'b1;
      end else if (mode == 2) begin
        start = 1'b0;
      end
      tick();
    end
    fall_c = cyc;
    check("DONE with TXEN drop", 64'(done), 64'd1);
    check("no DONE while TXEN high", 64'(done_in), 64'd0);
  endtask

  task automatic wait_gap();
    repeat (IFG - 1) tick();
    check("BUSY low after gap", 64'(busy), 64'd0);
  endtask

  initial begin
    int k, bad, prev_fall, L, idle;
    int exp_cnt;
    exp_cnt = 0;

    // Reset and idle
    repeat (3) tick();
    check("reset TXEN", 64'(txen), 64'd0);
    check("reset BUSY", 64'(busy), 64'd0);
    check("reset DONE", 64'(done), 64'd0);
    check("reset FRM_CNT", 64'(frm_cnt), 64'd0);
    check("reset TXD", 64'(txd), 64'd0);
    check("reset TXER", 64'(txer), 64'd0);
    arstn = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (txen !== 1'b0 || busy !== 1'b0 || txer !== 1'b0 || frm_cnt !== 32'd0) bad++;
    end
    check("idle quiet 20 cycles", 64'(bad), 64'd0);

    // Single frame, L=18
    pay_len = 11'd18;
    start = 1'b1;
    tick();
    k = cyc;
    start = 1'b0;
    check("BUSY after START", 64'(busy), 64'd1);
    get_frame(0, -1);
    check("START to TXEN latency", 64'(rise_c - k), 64'd13);
    check("TXEN length L=18", 64'(fall_c - rise_c), 64'd72);
    build_expected(18, 32'(exp_cnt));
    compare_frame("L=18");
    check("IP len L=18", 64'({got_q[24], got_q[25]}), 64'h002E);
    check("UDP len L=18", 64'({got_q[46], got_q[47]}), 64'h001A);
    check("IP checksum L=18", 64'({got_q[32], got_q[33]}), 64'({exp_q[32], exp_q[33]}));
    check("payload first L=18", 64'(got_q[50]), 64'h00);
    check("payload last L=18", 64'(got_q[67]), 64'h11);
    exp_cnt++;
    check("FRM_CNT after frame 1", 64'(frm_cnt), 64'(exp_cnt));
    check("BUSY during gap", 64'(busy), 64'd1);
    tick();
    check("DONE single pulse", 64'(done), 64'd0);
    repeat (IFG - 3) tick();
    check("BUSY until gap end", 64'(busy), 64'd1);
    tick();
    check("BUSY at gap exit", 64'(busy), 64'd0);

    // Empty payload
    pay_len = 11'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    get_frame(0, -1);
    check("TXEN length L=0", 64'(fall_c - rise_c), 64'd72);
    build_expected(0, 32'(exp_cnt));
    compare_frame("L=0");
    check("IP len L=0", 64'({got_q[24], got_q[25]}), 64'h001C);
    check("UDP len L=0", 64'({got_q[46], got_q[47]}), 64'h0008);
    exp_cnt++;
    check("FRM_CNT after L=0", 64'(frm_cnt), 64'(exp_cnt));
    wait_gap();

    // Clamped payload
    pay_len = 11'd2000;
    start = 1'b1;
    tick();
    start = 1'b0;
    get_frame(0, -1);
    check("TXEN length clamped", 64'(fall_c - rise_c), 64'd1526);
    build_expected(2000, 32'(exp_cnt));
    compare_frame("L=2000");
    check("IP len clamped", 64'({got_q[24], got_q[25]}), 64'h05DC);
    exp_cnt++;
    wait_gap();

    // Continuous mode from a fresh reset
    arstn = 1'b0;
    #1;
    tick();
    arstn = 1'b1;
    exp_cnt = 0;
    cont = 1'b1;
    pay_len = 11'd100;
    prev_fall = 0;
    for (int f = 0; f < 3; f++) begin
      get_frame((f == 2) ? 1 : 0, 30);
      if (f > 0) check("CONT wire gap", 64'(rise_c - prev_fall), 64'd24);
      prev_fall = fall_c;
      build_expected(100, 32'(f));
      compare_frame("CONT frame");
      check("CONT IP ID", 64'({got_q[26], got_q[27]}), 64'(f));
`ifdef PKTGEN_SEQNUM_EN
      check("CONT seqnum byte", 64'(got_q[53]), 64'(f));
      check("CONT pattern after seqnum", 64'(got_q[54]), 64'(f + 4));
`else
      check("CONT first payload", 64'(got_q[50]), 64'(f));
`endif
      check("CONT FRM_CNT", 64'(frm_cnt), 64'(f + 1));
    end
    exp_cnt = 3;
    wait_gap();
    bad = 0;
    repeat (60) begin
      tick();
      if (txen !== 1'b0) bad++;
    end
    check("no frame after CONT drop", 64'(bad), 64'd0);

    // START while busy is ignored
    pay_len = 11'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    get_frame(2, 20);
    build_expected(30, 32'(exp_cnt));
    compare_frame("START in HDR");
    exp_cnt++;
    wait_gap();
    bad = 0;
    repeat (60) begin
      tick();
      if (txen !== 1'b0) bad++;
    end
    check("no extra frame", 64'(bad), 64'd0);
    check("FRM_CNT no extra", 64'(frm_cnt), 64'(exp_cnt));

    // Reset in the middle of the payload
    pay_len = 11'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (txen !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check("TXEN rise before reset", 64'(txen), 64'd1);
    repeat (60) tick();
    check("TXEN high mid-payload", 64'(txen), 64'd1);
    arstn = 1'b0;
    #1;
    check("async reset TXEN", 64'(txen), 64'd0);
    check("async reset FRM_CNT", 64'(frm_cnt), 64'd0);
    check("async reset DONE", 64'(done), 64'd0);
    check("async reset BUSY", 64'(busy), 64'd0);
    tick();
    tick();
    arstn = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (txen !== 1'b0 || done !== 1'b0) bad++;
    end
    check("no restart after reset", 64'(bad), 64'd0);
    exp_cnt = 0;

    // Random lengths; PAY_LEN scrambled after sampling
    for (int r = 0; r < 4; r++) begin
      L = int'($urandom_range(0, 300));
      idle = int'($urandom_range(0, 5));
      repeat (idle) tick();
      pay_len = 11'(L);
      start = 1'b1;
      tick();
      start = 1'b0;
      pay_len = 11'($urandom);
      get_frame(0, -1);
      check("random TXEN length", 64'(fall_c - rise_c), 64'(54 + ((L > 18) ? L : 18)));
      build_expected(L, 32'(exp_cnt));
      compare_frame("random");
      exp_cnt++;
      check("random FRM_CNT", 64'(frm_cnt), 64'(exp_cnt));
      wait_gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
